// File: rtl/adder_result_accum.sv
// Sums each valid {cout, sum} result of a fixed-latency adder and emits one total per block of N_TERMS results.
// Optional feature macro ACCUM_SATURATE_EN: clamp totals at all-ones and report the clamp on out_sat.
module adder_result_accum #(
   parameter int DATA_W  = 32,
   parameter int ACC_W   = 34,
   parameter int LAT     = 2,
   parameter int N_TERMS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       op_valid,
   input  logic [DATA_W-1:0]          sum,
   input  logic                       cout,
   input  logic                       clr,
   output logic [ACC_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sat,
   output logic                       drop,
   output logic [$clog2(N_TERMS)-1:0] term_cnt
);
   localparam int CNT_W = $clog2(N_TERMS);
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   logic [LAT-1:0]   r_valid_line;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_term_cnt;
   logic [ACC_W-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_drop;

   logic             w_res_valid;
   logic             w_complete;
   logic             w_load;
   logic [ACC_W-1:0] w_addend;
   logic [ACC_W-1:0] w_total;

   assign w_res_valid = r_valid_line[LAT-1];
   assign w_addend    = ACC_W'({cout, sum});
   assign w_complete  = w_res_valid && (r_term_cnt == LAST_TERM);
   // The single output slot can take a new total if it is empty or being drained this cycle.
   assign w_load      = w_complete && (!r_out_valid || out_ready);

`ifdef ACCUM_SATURATE_EN
   logic [ACC_W:0] w_sum_full;
   logic           w_ovf;
   logic           r_blk_sat;
   logic           r_out_sat;

   assign w_sum_full = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_ovf      = w_sum_full[ACC_W];
   assign w_total    = w_ovf ? '1 : w_sum_full[ACC_W-1:0];

   // Block-level clamp flag; it follows the total into the output slot only when that total is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_sat <= 1'b0;
         r_out_sat <= 1'b0;
      end else if (clr) begin
         r_blk_sat <= 1'b0;
         r_out_sat <= 1'b0;
      end else if (w_complete) begin
         r_blk_sat <= 1'b0;
         if (w_load) begin
            r_out_sat <= r_blk_sat | w_ovf;
         end
      end else if (w_res_valid && w_ovf) begin
         r_blk_sat <= 1'b1;
      end
   end

   assign out_sat = r_out_sat;
`else
   assign w_total = r_acc + w_addend;
   assign out_sat = 1'b0;
`endif

   // Valid bits ride alongside the adder pipeline so only real results are counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_line <= '0;
      end else if (clr) begin
         r_valid_line <= '0;
      end else begin
         r_valid_line[0] <= op_valid;
         for (int i = 1; i < LAT; i++) begin
            r_valid_line[i] <= r_valid_line[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_term_cnt  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_drop      <= 1'b0;
      end else if (clr) begin
         r_acc       <= '0;
         r_term_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         if (w_complete) begin
            r_acc      <= '0;
            r_term_cnt <= '0;
         end else if (w_res_valid) begin
            r_acc      <= w_total;
            r_term_cnt <= r_term_cnt + CNT_W'(1);
         end

         // The adder cannot stall, so a total arriving at a full slot is dropped.
         if (w_load) begin
            r_out_data  <= w_total;
            r_out_valid <= 1'b1;
         end else if (w_complete) begin
            r_drop <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign drop      = r_drop;
   assign term_cnt  = r_term_cnt;

endmodule
